rvv_insn_sequencer: RTL and testbench

- Synthesizable, parametrised instruction player that feeds the insn_in port of rvv_proc_main.
- Software or bench preloads a program of up to DEPTH instructions, each with a per-entry hold count.
- On start, the block issues the program over a valid/ready handshake, inserting NOP gaps between entries, with optional looping and abort.
- Replaces hand-timed instruction stimulus in bring-up benches and FPGA smoke tests.

---
 rtl/rvv_seq_pkg.sv | 24 ++
 rtl/rvv_seq_prog_mem.sv | 38 +++
 rtl/rvv_insn_sequencer.sv | 168 ++++++++++++++++
 tb/tb_rvv_insn_sequencer.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rvv_seq_pkg.sv
// rtl/rvv_seq_pkg.sv - shared types and constants for the RVV instruction sequencer
// Contents: seq_state_t playback states, RVV_NOP filler word, prog_entry_t
// program entry layout at the default widths (32-bit insn, 8-bit hold).
package rvv_seq_pkg;

  localparam int SEQ_INSN_W = 32;
  localparam int SEQ_HOLD_W = 8;

  // Value driven on insn_out whenever no real instruction is presented.
  localparam logic [63:0] RVV_NOP = '0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    HOLD  = 2'd2,
    DONE  = 2'd3
  } seq_state_t;

  typedef struct packed {
    logic [SEQ_INSN_W-1:0] insn;
    logic [SEQ_HOLD_W-1:0] hold;
  } prog_entry_t;

endpackage

// File: rtl/rvv_seq_prog_mem.sv
// rtl/rvv_seq_prog_mem.sv - program store for the RVV instruction sequencer
// Ports:
//   clk_i         clock
//   we_i          write strobe (caller guarantees waddr_i < DEPTH and idle state)
//   waddr_i       write index
//   winsn_i       instruction to store
//   whold_i       NOP gap count to store
//   raddr_i       read index (playback pointer)
//   rinsn_o       instruction at raddr_i (combinational)
//   rhold_o       gap count at raddr_i (combinational)
// Contents are deliberately not reset.
module rvv_seq_prog_mem #(
  parameter int INSN_WIDTH = 32,
  parameter int DEPTH      = 16,
  parameter int HOLD_W     = 8,
  parameter int ADDR_W     = $clog2(DEPTH)
) (
  input  logic                  clk_i,
  input  logic                  we_i,
  input  logic [ADDR_W-1:0]     waddr_i,
  input  logic [INSN_WIDTH-1:0] winsn_i,
  input  logic [HOLD_W-1:0]     whold_i,
  input  logic [ADDR_W-1:0]     raddr_i,
  output logic [INSN_WIDTH-1:0] rinsn_o,
  output logic [HOLD_W-1:0]     rhold_o
);

  logic [INSN_WIDTH+HOLD_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= {winsn_i, whold_i};
    end
  end

  assign {rinsn_o, rhold_o} = mem_q[raddr_i];

endmodule

// File: rtl/rvv_insn_sequencer.sv
// rtl/rvv_insn_sequencer.sv - preloaded instruction player feeding rvv_proc_main insn_in
// Ports:
//   clk, rst (async active-low)
//   prog_we/prog_addr/prog_insn/prog_hold  program write port (IDLE/DONE only)
//   prog_len     entry count, sampled and clamped to DEPTH at start
//   start        begin playback from entry 0
//   loop_en      wrap to entry 0 after the last entry (sampled at each wrap)
//   abort        return to IDLE immediately, no done pulse
//   insn_out/insn_valid/insn_ready  valid/ready instruction stream
//   busy         high in ISSUE or HOLD
//   done         one-cycle pulse on normal completion
//   issue_cnt    handshakes since the last start
module rvv_insn_sequencer
  import rvv_seq_pkg::*;
#(
  parameter  int INSN_WIDTH = 32,
  parameter  int DEPTH      = 16,
  parameter  int HOLD_W     = 8,
  localparam int ADDR_W     = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  prog_we,
  input  logic [ADDR_W-1:0]     prog_addr,
  input  logic [INSN_WIDTH-1:0] prog_insn,
  input  logic [HOLD_W-1:0]     prog_hold,
  input  logic [ADDR_W:0]       prog_len,
  input  logic                  start,
  input  logic                  loop_en,
  input  logic                  abort,
  output logic [INSN_WIDTH-1:0] insn_out,
  output logic                  insn_valid,
  input  logic                  insn_ready,
  output logic                  busy,
  output logic                  done,
  output logic [31:0]           issue_cnt
);

  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

  seq_state_t            state_q, state_d;
  logic [ADDR_W-1:0]     ptr_q, ptr_d;
  logic [HOLD_W-1:0]     hold_cnt_q, hold_cnt_d;
  logic [ADDR_W:0]       len_q, len_d;
  logic [31:0]           issue_cnt_q, issue_cnt_d;

  logic [INSN_WIDTH-1:0] rd_insn;
  logic [HOLD_W-1:0]     rd_hold;
  logic                  mem_we;
  logic [ADDR_W:0]       len_clamped;
  logic                  handshake;
  logic                  last_entry;
  logic                  advance;

  // Writes only land while not playing; out-of-range indices are discarded
  // (possible only when DEPTH is not a power of two).
  assign mem_we = prog_we && ((state_q == IDLE) || (state_q == DONE))
                  && ({1'b0, prog_addr} < DEPTH_L);

  rvv_seq_prog_mem #(
    .INSN_WIDTH (INSN_WIDTH),
    .DEPTH      (DEPTH),
    .HOLD_W     (HOLD_W),
    .ADDR_W     (ADDR_W)
  ) u_prog_mem (
    .clk_i   (clk),
    .we_i    (mem_we),
    .waddr_i (prog_addr),
    .winsn_i (prog_insn),
    .whold_i (prog_hold),
    .raddr_i (ptr_q),
    .rinsn_o (rd_insn),
    .rhold_o (rd_hold)
  );

  assign len_clamped = (prog_len > DEPTH_L) ? DEPTH_L : prog_len;
  assign handshake   = (state_q == ISSUE) && insn_ready;
  assign last_entry  = ({1'b0, ptr_q} == (len_q - (ADDR_W+1)'(1)));

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    hold_cnt_d  = hold_cnt_q;
    len_d       = len_q;
    issue_cnt_d = issue_cnt_q;
    advance     = 1'b0;

    case (state_q)
      IDLE: begin
        if (start && !abort) begin
          len_d       = len_clamped;
          ptr_d       = '0;
          hold_cnt_d  = '0;
          issue_cnt_d = '0;
          state_d     = (len_clamped == '0) ? DONE : ISSUE;
        end
      end
      ISSUE: begin
        if (handshake) begin
          issue_cnt_d = issue_cnt_q + 32'd1;
          hold_cnt_d  = rd_hold;
          if (rd_hold != '0) begin
            state_d = HOLD;
          end else begin
            advance = 1'b1;
          end
        end
      end
      HOLD: begin
        // The cycle that sees a count of 1 is the last NOP cycle, so the
        // entry's hold value equals the number of NOP cycles emitted.
        if (hold_cnt_q <= HOLD_W'(1)) begin
          hold_cnt_d = '0;
          advance    = 1'b1;
        end else begin
          hold_cnt_d = hold_cnt_q - HOLD_W'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (advance) begin
      if (!last_entry) begin
        ptr_d   = ptr_q + ADDR_W'(1);
        state_d = ISSUE;
      end else if (loop_en) begin
        ptr_d   = '0;
        state_d = ISSUE;
      end else begin
        state_d = DONE;
      end
    end

    // A handshake in the abort cycle has already been counted above.
    if (abort) begin
      state_d    = IDLE;
      hold_cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      hold_cnt_q  <= '0;
      len_q       <= '0;
      issue_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      hold_cnt_q  <= hold_cnt_d;
      len_q       <= len_d;
      issue_cnt_q <= issue_cnt_d;
    end
  end

  assign insn_valid = (state_q == ISSUE);
  assign insn_out   = insn_valid ? rd_insn : INSN_WIDTH'(RVV_NOP);
  assign busy       = (state_q == ISSUE) || (state_q == HOLD);
  assign done       = (state_q == DONE);
  assign issue_cnt  = issue_cnt_q;

endmodule

// File: tb/tb_rvv_insn_sequencer.sv
// tb/tb_rvv_insn_sequencer.sv - self-checking bench for rvv_insn_sequencer
module tb_rvv_insn_sequencer;
  import rvv_seq_pkg::*;

  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic          clk;
  logic          rst;
  logic          prog_we;
  logic [AW-1:0] prog_addr;
  logic [31:0]   prog_insn;
  logic [7:0]    prog_hold;
  logic [AW:0]   prog_len;
  logic          start;
  logic          loop_en;
  logic          abort;
  logic [31:0]   insn_out;
  logic          insn_valid;
  logic          insn_ready;
  logic          busy;
  logic          done;
  logic [31:0]   issue_cnt;

  rvv_insn_sequencer #(.INSN_WIDTH(32), .DEPTH(DEPTH), .HOLD_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .prog_we    (prog_we),
    .prog_addr  (prog_addr),
    .prog_insn  (prog_insn),
    .prog_hold  (prog_hold),
    .prog_len   (prog_len),
    .start      (start),
    .loop_en    (loop_en),
    .abort      (abort),
    .insn_out   (insn_out),
    .insn_valid (insn_valid),
    .insn_ready (insn_ready),
    .busy       (busy),
    .done       (done),
    .issue_cnt  (issue_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;
  int n_done  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    else n_pass++;
  endtask

  // Reference model: program contents, expected playback order, gap lengths,
  // handshake count and completion, derived from the observable rules.
  prog_entry_t m_prog [DEPTH];
  bit m_on = 0, m_new = 0, m_wrap = 0, m_prev_loop = 0;
  int m_idx = 0, m_len = 0, m_gap = 0, m_exp_gap = 0;
  logic [31:0] m_cnt = 0;

  always @(negedge clk) begin
    bit on_entry;
    if (!rst) begin
      m_on = 0; m_cnt = 0; m_wrap = 0; m_new = 0;
      chk("rst_valid", insn_valid, 0);
      chk("rst_out", insn_out, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_cnt", issue_cnt, 0);
    end else begin
      on_entry = m_on;
      chk("issue_cnt", issue_cnt, m_cnt);
      chk("busy", busy, m_on && !done);
      if (!m_on) chk("spurious_done", done, 0);
      if (!insn_valid) begin
        chk("nop_out", insn_out, 0);
        if (m_on) m_gap++;
      end else begin
        chk("spurious_valid", insn_valid, m_on);
        if (m_on) begin
          chk("insn", insn_out, m_prog[m_idx].insn);
          if (m_new) begin
            chk("gap", m_gap, m_exp_gap);
            if (m_wrap) chk("wrap_needs_loop", insn_valid, m_prev_loop);
            m_new = 0; m_wrap = 0;
          end
        end
      end
      if (done && m_on) begin
        chk("done_gap", m_gap, m_exp_gap + 1);
        chk("done_at_end", done, (m_len == 0) || (m_wrap && !m_prev_loop));
        n_done++;
        m_on = 0;
      end
      if (insn_valid && insn_ready) begin
        m_cnt++;
        if (m_on) begin
          m_exp_gap = m_prog[m_idx].hold;
          m_gap = 0; m_new = 1;
          m_wrap = (m_idx == m_len - 1);
          m_idx = m_wrap ? 0 : m_idx + 1;
        end
      end
      if (prog_we && !on_entry && prog_addr < DEPTH) m_prog[prog_addr] = {prog_insn, prog_hold};
      if (abort) m_on = 0;
      else if (start && !on_entry) begin
        m_on = 1; m_len = (prog_len > DEPTH) ? DEPTH : prog_len;
        m_idx = 0; m_cnt = 0; m_gap = 0; m_exp_gap = 0; m_new = 1; m_wrap = 0;
      end
      m_prev_loop = loop_en;
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic write(input int addr, input logic [31:0] insn, input logic [7:0] hold);
    prog_we = 1; prog_addr = AW'(addr); prog_insn = insn; prog_hold = hold;
    tick();
    prog_we = 0;
  endtask

  task automatic pulse_start(input int len);
    prog_len = (AW+1)'(len); start = 1;
    tick();
    start = 0;
  endtask

  task automatic wait_done(input int budget);
    int d0 = n_done;
    int k = 0;
    while (n_done == d0 && k < budget) begin tick(); k++; end
    if (n_done == d0) chk("done_timeout", n_done - d0, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int d0;
    rst = 0; prog_we = 0; prog_addr = 0; prog_insn = 0; prog_hold = 0;
    prog_len = 0; start = 0; loop_en = 0; abort = 0; insn_ready = 1;
    #2;
    chk("init_valid", insn_valid, 0);
    chk("init_cnt", issue_cnt, 0);
    chk("init_busy", busy, 0);
    tick(); tick();
    rst = 1;
    tick();

    // Back-to-back issue of three entries
    write(0, 32'habcef012, 0);
    write(1, 32'h98765432, 0);
    write(2, 32'h00001057, 0);
    d0 = n_done;
    pulse_start(3);
    chk("t1_e0", insn_out, 32'habcef012); chk("t1_v0", insn_valid, 1);
    tick(); chk("t1_e1", insn_out, 32'h98765432);
    tick(); chk("t1_e2", insn_out, 32'h00001057);
    tick(); chk("t1_done", done, 1); chk("t1_cnt", issue_cnt, 3); chk("t1_v3", insn_valid, 0);
    tick(); chk("t1_done_clr", done, 0);
    tick(); chk("t1_done_once", n_done - d0, 1);

    // Backpressure on entry 1
    pulse_start(3);
    tick(); chk("t3_e1", insn_out, 32'h98765432);
    insn_ready = 0;
    for (int i = 0; i < 5; i++) begin
      chk("t3_hold_insn", insn_out, 32'h98765432);
      chk("t3_hold_valid", insn_valid, 1);
      chk("t3_hold_cnt", issue_cnt, 1);
      tick();
    end
    insn_ready = 1;
    tick(); chk("t3_e2", insn_out, 32'h00001057); chk("t3_cnt2", issue_cnt, 2);
    wait_done(10);
    chk("t3_cnt_end", issue_cnt, 3);

    // Looping, then drop loop_en
    loop_en = 1;
    pulse_start(2);
    repeat (7) tick();
    chk("t4_cnt7", issue_cnt, 7); chk("t4_e1", insn_out, 32'h98765432);
    loop_en = 0;
    tick(); chk("t4_done", done, 1); chk("t4_cnt8", issue_cnt, 8);
    tick();

    // Hold gap of 4 cycles
    write(0, 32'h11111111, 4);
    write(1, 32'h22222222, 0);
    pulse_start(2);
    chk("t2_e0", insn_out, 32'h11111111);
    for (int i = 0; i < 4; i++) begin
      tick(); chk("t2_gap_valid", insn_valid, 0); chk("t2_gap_out", insn_out, 0); chk("t2_gap_busy", busy, 1);
    end
    tick(); chk("t2_e1", insn_out, 32'h22222222); chk("t2_e1_v", insn_valid, 1);
    tick(); chk("t2_done", done, 1);
    tick();

    // Abort during HOLD; write while busy is dropped
    write(0, 32'h44444444, 5);
    write(1, 32'h55555555, 0);
    pulse_start(2);
    prog_we = 1; prog_addr = 1; prog_insn = 32'hdeadbeef; prog_hold = 7;
    tick();
    prog_we = 0;
    tick(); tick();
    chk("t5_in_hold", busy, 1);
    d0 = n_done;
    abort = 1;
    tick();
    abort = 0;
    chk("t5_busy", busy, 0); chk("t5_valid", insn_valid, 0); chk("t5_done", done, 0);
    tick(); chk("t5_no_done", n_done - d0, 0);
    write(0, 32'h66666666, 0);
    pulse_start(2);
    chk("t5_new_e0", insn_out, 32'h66666666);
    tick(); chk("t5_kept_e1", insn_out, 32'h55555555);
    wait_done(10);

    // Zero length
    pulse_start(0);
    chk("t6_done", done, 1); chk("t6_valid", insn_valid, 0);
    tick(); chk("t6_done_clr", done, 0);

    // Length clamp to DEPTH
    for (int i = 0; i < DEPTH; i++) write(i, 32'h1000 + i, 0);
    pulse_start(DEPTH + 5);
    chk("t7_e0", insn_out, 32'h1000);
    wait_done(60);
    chk("t7_cnt", issue_cnt, DEPTH);

    // Async reset mid-ISSUE
    pulse_start(3);
    tick(); chk("t8_cnt1", issue_cnt, 1);
    insn_ready = 0;
    tick();
    #2 rst = 0;
    #1;
    chk("t8_valid", insn_valid, 0); chk("t8_out", insn_out, 0);
    chk("t8_busy", busy, 0); chk("t8_cnt", issue_cnt, 0); chk("t8_done", done, 0);
    tick();
    rst = 1; insn_ready = 1;
    tick(); tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
